// File: rtl/beep_note_player.sv
// beep_note_player: walks a note ROM one beat per address and drives a square wave.
// Define PLAYER_LOOP_EN to restart at address 0 after the last note while en stays high.
module beep_note_player #(
    parameter int BEAT_CYCLES  = 12_500_000,
    parameter int GAP_CYCLES   = 500_000,
    parameter int NOTE_NUM     = 32,
    parameter int PERIOD_SHIFT = 0
) (
    input  logic        sclk,
    input  logic        nrst,
    input  logic        en,
    output logic [15:0] rom_addr,
    input  logic [4:0]  rom_data,
    output logic        beep,
    output logic        busy,
    output logic        done
);

`ifdef PLAYER_LOOP_EN
    localparam logic LOOP = 1'b1;
`else
    localparam logic LOOP = 1'b0;
`endif

    localparam int CMAX = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [15:0]   ADDR_LAST = 16'(NOTE_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [4:0]    note_reg;
    logic [17:0]   period;
    logic [17:0]   half;
    logic [17:0]   pcnt;
    logic [17:0]   pnext;
    logic [CW-1:0] cnt;
    logic          spent;
    logic          beat_end;
    logic          gap_end;
    logic          last_note;

    function automatic logic [17:0] note_period(input logic [4:0] code);
        logic [17:0] base;
        logic [4:0]  idx;
        logic [1:0]  oct;
        idx = '0;
        oct = 2'd3;
        unique case (1'b1)
            (code >= 5'd1 && code <= 5'd7): begin
                idx = code - 5'd1;
                oct = 2'd0;
            end
            (code >= 5'd8 && code <= 5'd14): begin
                idx = code - 5'd8;
                oct = 2'd1;
            end
            (code >= 5'd15 && code <= 5'd21): begin
                idx = code - 5'd15;
                oct = 2'd2;
            end
            default: oct = 2'd3;
        endcase
        case (idx)
            5'd0:    base = 18'd191113;
            5'd1:    base = 18'd170262;
            5'd2:    base = 18'd151686;
            5'd3:    base = 18'd143173;
            5'd4:    base = 18'd127552;
            5'd5:    base = 18'd113636;
            5'd6:    base = 18'd101238;
            default: base = '0;
        endcase
        if (oct == 2'd3) base = '0;
        return (base >> oct) >> PERIOD_SHIFT;
    endfunction

    // LOAD decodes straight from the ROM so the first PLAY cycle is already high
    assign period    = note_period((state == S_LOAD) ? rom_data : note_reg);
    assign half      = period >> 1;
    assign pnext     = (state == S_LOAD || pcnt == period - 18'd1) ? '0 : pcnt + 18'd1;
    assign beat_end  = (state == S_PLAY) && (cnt == BEAT_LAST);
    assign gap_end   = (state == S_GAP) && (cnt == GAP_LAST);
    assign last_note = (rom_addr == ADDR_LAST);

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (!en) begin
            state_d = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (!spent) state_d = S_FETCH;
                S_FETCH: state_d = S_LOAD;
                S_LOAD:  state_d = S_PLAY;
                S_PLAY:  if (beat_end) state_d = S_GAP;
                S_GAP: begin
                    if (gap_end)
                        state_d = (last_note && !LOOP) ? S_IDLE : S_FETCH;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // spent blocks a replay until en has been seen low
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            rom_addr <= '0;
            note_reg <= '0;
            pcnt     <= '0;
            cnt      <= '0;
            beep     <= 1'b0;
            done     <= 1'b0;
            spent    <= 1'b0;
        end else if (!en) begin
            rom_addr <= '0;
            pcnt     <= '0;
            cnt      <= '0;
            beep     <= 1'b0;
            done     <= 1'b0;
            spent    <= 1'b0;
        end else begin
            done <= 1'b0;
            beep <= 1'b0;
            case (state)
                S_LOAD: begin
                    note_reg <= rom_data;
                    pcnt     <= pnext;
                    cnt      <= '0;
                    beep     <= (pnext < half);
                end
                S_PLAY: begin
                    pcnt <= pnext;
                    beep <= !beat_end && (pnext < half);
                    cnt  <= beat_end ? '0 : cnt + CW'(1);
                end
                S_GAP: begin
                    if (gap_end) begin
                        cnt <= '0;
                        if (last_note) begin
                            rom_addr <= '0;
                            done     <= 1'b1;
                            spent    <= ~LOOP;
                        end else begin
                            rom_addr <= rom_addr + 16'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_beep_note_player.sv
// tb_beep_note_player: directed checks of note playback, rests, wrap, en drop and reset.
// Expected waveforms are hand-derived from the LUT periods shifted right by 8.
module tb_beep_note_player;

    localparam int BEAT  = 4000;
    localparam int GAP   = 50;
    localparam int NN    = 4;
    localparam int SHIFT = 8;
    localparam int WIN   = 2 + BEAT + GAP;

`ifdef PLAYER_LOOP_EN
    localparam logic LOOP = 1'b1;
`else
    localparam logic LOOP = 1'b0;
`endif

    typedef struct packed {
        int hi;
        int rises;
        int frise;
        int ffall;
        int srise;
        int lhigh;
        int busy_low;
        int done_cnt;
        int moves;
    } stat_t;

    // window starts at the FETCH cycle: FETCH, LOAD, 4000 PLAY, 50 GAP
    localparam stat_t C4   = '{2135, 6, 2, 375, 748, 4001, 0, 0, 0};
    localparam stat_t REST = '{0, 0, -1, -1, -1, -1, 0, 0, 0};
    localparam stat_t C5   = '{2046, 11, 2, 188, 375, 3917, 0, 0, 0};
    localparam stat_t B6   = '{2009, 41, 2, 51, 100, 3970, 0, 0, 0};

    logic        sclk;
    logic        nrst;
    logic        en;
    logic [15:0] rom_addr;
    logic [4:0]  rom_data;
    logic        beep;
    logic        busy;
    logic        done;
    logic [4:0]  rom [4] = '{5'd1, 5'd0, 5'd8, 5'd21};

    int vecs = 0;
    int miss = 0;

    beep_note_player #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP),
        .NOTE_NUM    (NN),
        .PERIOD_SHIFT(SHIFT)
    ) dut (
        .sclk    (sclk),
        .nrst    (nrst),
        .en      (en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .beep    (beep),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    always_ff @(posedge sclk) rom_data <= rom[rom_addr[1:0]];

    function automatic string fmt(input stat_t s);
        return $sformatf("hi=%0d rises=%0d frise=%0d ffall=%0d srise=%0d lhigh=%0d busylow=%0d done=%0d moves=%0d",
                         s.hi, s.rises, s.frise, s.ffall, s.srise, s.lhigh,
                         s.busy_low, s.done_cnt, s.moves);
    endfunction

    task automatic watch(input int n, output stat_t s);
        logic        prev;
        logic [15:0] a0;
        s = '{0, 0, -1, -1, -1, -1, 0, 0, 0};
        prev = 1'b0;
        a0 = rom_addr;
        for (int i = 0; i < n; i++) begin
            if (beep === 1'b1) begin
                s.hi++;
                s.lhigh = i;
                if (!prev) begin
                    s.rises++;
                    if (s.frise < 0) s.frise = i;
                    else if (s.srise < 0) s.srise = i;
                end
            end else if (prev && s.ffall < 0) begin
                s.ffall = i;
            end
            if (busy !== 1'b1) s.busy_low++;
            if (done !== 1'b0) s.done_cnt++;
            if (rom_addr !== a0) s.moves++;
            prev = (beep === 1'b1);
            @(negedge sclk);
        end
    endtask

    task automatic test_reset();
        int bad;
        #17;
        vecs++;
        if ({rom_addr, beep, busy, done} !== 19'd0) begin
            miss++;
            $display("FAIL reset_outs got addr=%0d beep=%b busy=%b done=%b want all 0",
                     rom_addr, beep, busy, done);
        end
        #3 nrst = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge sclk);
            if (busy !== 1'b0 || beep !== 1'b0 || done !== 1'b0 || rom_addr !== 16'd0) bad++;
        end
        vecs++;
        if (bad !== 0) begin
            miss++;
            $display("FAIL idle_en0 got %0d busy cycles want 0", bad);
        end
    endtask

    task automatic test_c4();
        stat_t s;
        en = 1'b1;
        @(negedge sclk);
        watch(WIN, s);
        vecs++;
        if (s.frise + 1 !== 3) begin
            miss++;
            $display("FAIL c4_latency got %0d want 3", s.frise + 1);
        end
        vecs++;
        if (s !== C4) begin
            miss++;
            $display("FAIL c4_note got %s want %s", fmt(s), fmt(C4));
        end
        vecs++;
        if (rom_addr !== 16'd1) begin
            miss++;
            $display("FAIL c4_next_addr got %0d want 1", rom_addr);
        end
    endtask

    task automatic test_rest();
        stat_t s;
        watch(WIN, s);
        vecs++;
        if (s !== REST) begin
            miss++;
            $display("FAIL rest_note got %s want %s", fmt(s), fmt(REST));
        end
        vecs++;
        if (rom_addr !== 16'd2) begin
            miss++;
            $display("FAIL rest_next_addr got %0d want 2", rom_addr);
        end
    endtask

    task automatic test_c5();
        stat_t s;
        watch(WIN, s);
        vecs++;
        if (s !== C5) begin
            miss++;
            $display("FAIL c5_note got %s want %s", fmt(s), fmt(C5));
        end
        vecs++;
        if (rom_addr !== 16'd3) begin
            miss++;
            $display("FAIL c5_next_addr got %0d want 3", rom_addr);
        end
    endtask

    task automatic test_b6_wrap();
        stat_t s;
        int    bad;
        watch(WIN, s);
        vecs++;
        if (s !== B6) begin
            miss++;
            $display("FAIL b6_note got %s want %s", fmt(s), fmt(B6));
        end
        vecs++;
        if (done !== 1'b1 || rom_addr !== 16'd0) begin
            miss++;
            $display("FAIL wrap_done got done=%b addr=%0d want done=1 addr=0", done, rom_addr);
        end
        vecs++;
        if (busy !== LOOP) begin
            miss++;
            $display("FAIL wrap_busy got %b want %b", busy, LOOP);
        end
        @(negedge sclk);
        vecs++;
        if (done !== 1'b0) begin
            miss++;
            $display("FAIL done_width got %b want 0", done);
        end
        bad = 0;
        repeat (5) begin
            if (busy !== LOOP) bad++;
            @(negedge sclk);
        end
        vecs++;
        if (bad !== 0) begin
            miss++;
            $display("FAIL after_wrap_busy got %0d wrong cycles want 0", bad);
        end
    endtask

    task automatic test_en_drop();
        stat_t s;
        en = 1'b0;
        repeat (2) @(negedge sclk);
        en = 1'b1;
        @(negedge sclk);
        watch(WIN, s);
        vecs++;
        if (s !== C4) begin
            miss++;
            $display("FAIL replay_c4 got %s want %s", fmt(s), fmt(C4));
        end
        watch(WIN, s);
        repeat (102) @(negedge sclk);
        vecs++;
        if (beep !== 1'b1 || rom_addr !== 16'd2) begin
            miss++;
            $display("FAIL pre_drop got beep=%b addr=%0d want beep=1 addr=2", beep, rom_addr);
        end
        en = 1'b0;
        @(negedge sclk);
        vecs++;
        if ({rom_addr, beep, busy, done} !== 19'd0) begin
            miss++;
            $display("FAIL en_drop got addr=%0d beep=%b busy=%b done=%b want all 0",
                     rom_addr, beep, busy, done);
        end
        repeat (2) @(negedge sclk);
        en = 1'b1;
        @(negedge sclk);
    endtask

    task automatic test_async_reset();
        stat_t s;
        repeat (12) @(negedge sclk);
        vecs++;
        if (beep !== 1'b1 || busy !== 1'b1) begin
            miss++;
            $display("FAIL restart_play got beep=%b busy=%b want 1 1", beep, busy);
        end
        #2 nrst = 1'b0;
        #1;
        vecs++;
        if ({rom_addr, beep, busy, done} !== 19'd0) begin
            miss++;
            $display("FAIL async_reset got addr=%0d beep=%b busy=%b done=%b want all 0",
                     rom_addr, beep, busy, done);
        end
        @(negedge sclk);
        nrst = 1'b1;
        @(negedge sclk);
        watch(WIN, s);
        vecs++;
        if (s !== C4) begin
            miss++;
            $display("FAIL post_reset_c4 got %s want %s", fmt(s), fmt(C4));
        end
    endtask

    task automatic test_en_at_wrap();
        stat_t s;
        watch(WIN, s);
        watch(WIN, s);
        watch(WIN - 1, s);
        vecs++;
        if (s !== B6 || rom_addr !== 16'd3) begin
            miss++;
            $display("FAIL last_gap got %s addr=%0d want %s addr=3", fmt(s), rom_addr, fmt(B6));
        end
        en = 1'b0;
        @(negedge sclk);
        vecs++;
        if ({rom_addr, beep, busy, done} !== 19'd0) begin
            miss++;
            $display("FAIL en_at_wrap got addr=%0d beep=%b busy=%b done=%b want all 0",
                     rom_addr, beep, busy, done);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0;
        en   = 1'b0;
        test_reset();
        test_c4();
        test_rest();
        test_c5();
        test_b6_wrap();
        test_en_drop();
        test_async_reset();
        test_en_at_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
